// File: rtl/digit_scan_ring.sv
// Multiplexed display digit scanner: prescaled ring counter with one-hot digit select.
// Optional macro DIGIT_SCAN_SKIP_BLANK_EN makes a step skip blanked digits.
module digit_scan_ring #(
    parameter int N_DIG      = 4,
    parameter int PRESC_W    = 16,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int IW        = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               dir,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic [N_DIG-1:0]   blank_mask,
    input  logic               load,
    input  logic [IW-1:0]      load_idx,
    output logic [N_DIG-1:0]   sel,
    output logic [IW-1:0]      idx,
    output logic               tick,
    output logic               wrap
);

    localparam logic [IW-1:0] LAST = IW'(N_DIG - 1);

    logic [PRESC_W-1:0] cnt;
    logic [IW-1:0]      step_idx;
    logic               step_wrap;
    logic               load_ok;
    logic [N_DIG-1:0]   sel_hot;

    assign load_ok = (int'(load_idx) < N_DIG);

`ifdef DIGIT_SCAN_SKIP_BLANK_EN
    int   pos;
    logic found;
    logic crossed;

    // Search up to a full lap; landing back on idx itself counts as a boundary crossing.
    always_comb begin
        step_idx  = idx;
        step_wrap = 1'b0;
        pos       = 0;
        found     = 1'b0;
        crossed   = 1'b0;
        for (int k = 1; k <= N_DIG; k++) begin
            pos     = dir ? (int'(idx) - k) : (int'(idx) + k);
            crossed = (pos < 0) || (pos >= N_DIG);
            if (pos < 0) begin
                pos = pos + N_DIG;
            end else if (pos >= N_DIG) begin
                pos = pos - N_DIG;
            end
            if (!found && !blank_mask[pos[IW-1:0]]) begin
                found     = 1'b1;
                step_idx  = pos[IW-1:0];
                step_wrap = crossed;
            end
        end
    end
`else
    always_comb begin
        step_idx  = idx;
        step_wrap = 1'b0;
        if (!dir) begin
            if (idx == LAST) begin
                step_idx  = '0;
                step_wrap = 1'b1;
            end else begin
                step_idx = idx + IW'(1);
            end
        end else begin
            if (idx == '0) begin
                step_idx  = LAST;
                step_wrap = 1'b1;
            end else begin
                step_idx = idx - IW'(1);
            end
        end
    end
`endif

    // Load wins over stepping; an out-of-range load index falls back to digit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            idx  <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            cnt  <= '0;
            idx  <= load_ok ? load_idx : '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (en) begin
            if (cnt >= presc_div) begin
                cnt  <= '0;
                idx  <= step_idx;
                tick <= 1'b1;
                wrap <= step_wrap;
            end else begin
                cnt  <= cnt + PRESC_W'(1);
                tick <= 1'b0;
                wrap <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

    // sel is a pure decode of the registered idx, so it changes together with idx.
    always_comb begin
        sel_hot      = '0;
        sel_hot[idx] = ~blank_mask[idx];
        sel          = ACTIVE_LOW ? ~sel_hot : sel_hot;
    end

endmodule

// File: tb/tb_digit_scan_ring.sv
// Bench for digit_scan_ring: vector table through a scoreboard queue plus multi-cycle sequences.
module tb_digit_scan_ring;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, dir, load;
    logic [15:0] presc_div;
    logic [3:0]  blank_mask;
    logic [1:0]  load_idx;
    logic [3:0]  sel;
    logic [1:0]  idx;
    logic        tick, wrap;

    logic        en5, load5;
    logic [2:0]  load_idx5, idx5;
    logic [4:0]  sel5;
    logic        tick5, wrap5;

    logic        en2;
    logic [0:0]  idx2;
    logic [1:0]  sel2;
    logic        tick2, wrap2;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic        en, dir, load;
        logic [15:0] presc;
        logic [3:0]  mask;
        logic [1:0]  lidx;
        logic [1:0]  e_idx;
        logic [3:0]  e_sel;
        logic        e_tick, e_wrap;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    digit_scan_ring dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .presc_div(presc_div),
        .blank_mask(blank_mask), .load(load), .load_idx(load_idx),
        .sel(sel), .idx(idx), .tick(tick), .wrap(wrap)
    );

    digit_scan_ring #(.N_DIG(5), .ACTIVE_LOW(1'b0)) u5 (
        .clk(clk), .reset(reset), .en(en5), .dir(1'b1), .presc_div(16'd0),
        .blank_mask(5'b0), .load(load5), .load_idx(load_idx5),
        .sel(sel5), .idx(idx5), .tick(tick5), .wrap(wrap5)
    );

    digit_scan_ring #(.N_DIG(2)) u2 (
        .clk(clk), .reset(reset), .en(en2), .dir(1'b0), .presc_div(16'd0),
        .blank_mask(2'b0), .load(1'b0), .load_idx(1'b0),
        .sel(sel2), .idx(idx2), .tick(tick2), .wrap(wrap2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void add(input logic e, input logic d, input logic [15:0] p,
                                input logic [3:0] m, input logic l, input logic [1:0] li,
                                input logic [1:0] ei, input logic [3:0] es,
                                input logic et, input logic ew);
        vec_t v;
        v.en = e; v.dir = d; v.presc = p; v.mask = m; v.load = l; v.lidx = li;
        v.e_idx = ei; v.e_sel = es; v.e_tick = et; v.e_wrap = ew;
        vecs.push_back(v);
    endfunction

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until tick is seen, giving up after limit edges.
    task automatic wait_tick(input int limit, output int cycles);
        cycles = 0;
        do begin
            edge_sample();
            cycles++;
        end while (!tick && cycles < limit);
    endtask

    initial begin
        logic [7:0] got, req;
        int         cyc;

        reset = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; presc_div = '0;
        blank_mask = '0; load_idx = '0;
        en5 = 1'b0; load5 = 1'b0; load_idx5 = '0; en2 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {idx, sel, tick, wrap}, {2'd0, 4'b1110, 1'b0, 1'b0});
        check("reset_u5_sel", sel5, 5'b00001);
        check("reset_u2_sel", sel2, 2'b10);
        blank_mask = 4'b0001;
        #1;
        check("reset_blank0_sel", sel, 4'b1111);
        blank_mask = 4'b0000;
        reset = 1'b0;

        add(1,0,0,4'b0000,0,0, 2'd1,4'b1101,1,0);
        add(1,0,0,4'b0000,0,0, 2'd2,4'b1011,1,0);
        add(1,0,0,4'b0000,0,0, 2'd3,4'b0111,1,0);
        add(1,0,0,4'b0000,0,0, 2'd0,4'b1110,1,1);
        add(0,0,0,4'b0000,0,0, 2'd0,4'b1110,0,0);
        add(1,1,0,4'b0000,0,0, 2'd3,4'b0111,1,1);
        add(1,1,0,4'b0000,0,0, 2'd2,4'b1011,1,0);
        add(1,1,0,4'b0000,1,1, 2'd1,4'b1101,0,0);
        add(1,0,1,4'b0000,0,0, 2'd1,4'b1101,0,0);
        add(1,0,1,4'b0000,0,0, 2'd2,4'b1011,1,0);
        add(1,0,1,4'b0000,0,0, 2'd2,4'b1011,0,0);
        add(1,0,1,4'b0000,1,2, 2'd2,4'b1011,0,0);
        add(1,0,1,4'b0000,0,0, 2'd2,4'b1011,0,0);
        add(1,0,1,4'b0000,0,0, 2'd3,4'b0111,1,0);
        add(1,0,3,4'b0000,0,0, 2'd3,4'b0111,0,0);
        add(1,0,3,4'b0000,0,0, 2'd3,4'b0111,0,0);
        add(1,0,0,4'b0000,0,0, 2'd0,4'b1110,1,1);
`ifdef DIGIT_SCAN_SKIP_BLANK_EN
        add(1,0,0,4'b0100,0,0, 2'd1,4'b1101,1,0);
        add(1,0,0,4'b0100,0,0, 2'd3,4'b0111,1,0);
        add(1,0,0,4'b0100,0,0, 2'd0,4'b1110,1,1);
        add(1,0,0,4'b0100,0,0, 2'd1,4'b1101,1,0);
        add(0,0,0,4'b1111,0,0, 2'd1,4'b1111,0,0);
        add(1,0,0,4'b1111,0,0, 2'd1,4'b1111,1,0);
`else
        add(1,0,0,4'b0100,0,0, 2'd1,4'b1101,1,0);
        add(1,0,0,4'b0100,0,0, 2'd2,4'b1111,1,0);
        add(1,0,0,4'b0100,0,0, 2'd3,4'b0111,1,0);
        add(1,0,0,4'b0100,0,0, 2'd0,4'b1110,1,1);
        add(0,0,0,4'b1111,0,0, 2'd0,4'b1111,0,0);
        add(1,0,0,4'b1111,0,0, 2'd1,4'b1111,1,0);
`endif
        add(0,0,0,4'b0000,0,0, 2'd1,4'b1101,0,0);

        foreach (vecs[i]) begin
            en = vecs[i].en; dir = vecs[i].dir; presc_div = vecs[i].presc;
            blank_mask = vecs[i].mask; load = vecs[i].load; load_idx = vecs[i].lidx;
            exp_q.push_back({vecs[i].e_idx, vecs[i].e_sel, vecs[i].e_tick, vecs[i].e_wrap});
            edge_sample();
            got = {idx, sel, tick, wrap};
            req = exp_q.pop_front();
            check($sformatf("vec%0d", i), got, req);
        end

        // Period of four with a five-cycle freeze in the middle of a period.
        en = 1'b1; dir = 1'b0; presc_div = 16'd3; blank_mask = '0; load = 1'b1; load_idx = 2'd0;
        edge_sample();
        check("presc_load", {idx, tick}, {2'd0, 1'b0});
        load = 1'b0;
        wait_tick(20, cyc);
        check("presc_period1", cyc, 4);
        check("presc_idx1", idx, 2'd1);
        wait_tick(20, cyc);
        check("presc_period2", cyc, 4);
        check("presc_idx2", idx, 2'd2);
        edge_sample();
        edge_sample();
        check("presc_pre_freeze", {idx, tick}, {2'd2, 1'b0});
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_sample();
            check($sformatf("freeze%0d", i), {idx, sel, tick, wrap}, {2'd2, 4'b1011, 1'b0, 1'b0});
        end
        en = 1'b1;
        wait_tick(20, cyc);
        check("freeze_resume", cyc, 2);
        check("freeze_idx3", idx, 2'd3);

        // Reset in mid-count discards the partial period.
        edge_sample();
        edge_sample();
        #2 reset = 1'b1;
        #1;
        check("midcount_reset", {idx, sel, tick}, {2'd0, 4'b1110, 1'b0});
        reset = 1'b0;
        wait_tick(20, cyc);
        check("post_reset_period", cyc, 4);
        check("post_reset_idx", idx, 2'd1);

        // Asynchronous reset between edges right after a step.
        load = 1'b1; load_idx = 2'd2;
        edge_sample();
        load = 1'b0; presc_div = 16'd0;
        edge_sample();
        check("pre_async", {idx, tick}, {2'd3, 1'b1});
        #2 reset = 1'b1;
        #1;
        check("async_reset", {idx, sel, tick, wrap}, {2'd0, 4'b1110, 1'b0, 1'b0});
        #1 reset = 1'b0;
        en = 1'b0;

        // Five-digit active-high instance: range clamp on load and downward wrap.
        load5 = 1'b1; load_idx5 = 3'd4;
        edge_sample();
        check("u5_load4", {idx5, sel5}, {3'd4, 5'b10000});
        load_idx5 = 3'd7;
        edge_sample();
        check("u5_load_oor", {idx5, sel5, tick5}, {3'd0, 5'b00001, 1'b0});
        load5 = 1'b0; en5 = 1'b1;
        edge_sample();
        check("u5_down_wrap", {idx5, sel5, tick5, wrap5}, {3'd4, 5'b10000, 1'b1, 1'b1});
        en5 = 1'b0;

        // Two-digit instance alternates with a wrap on every second step.
        en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({3'b000, (i % 2 == 0) ? 1'b1 : 1'b0,
                             (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, (i % 2 == 1) ? 1'b1 : 1'b0});
            edge_sample();
            got = {3'b000, idx2, sel2, tick2, wrap2};
            req = exp_q.pop_front();
            check($sformatf("u2_step%0d", i), got, req);
        end
        en2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
